// File: rtl/song_sequencer.sv
// song_sequencer: programmable song player stepping a writable note RAM at a run-time tempo.
// Latency: note_code/songout/gate follow step_idx by 1 cycle (sync-read RAM); first note 2 cycles after play.
// Backpressure: none; the play level pauses (freezes) the song, outputs read 0 while paused/idle/done.
//
// Ports:
//   clk50, reset (async, active-low)
//   play, loop_en, tempo_div, song_len           - transport / tempo / length controls
//   wr_en, wr_addr, wr_data                      - song RAM write port (any state, read-first)
//   note_table                                   - packed pitch table, code k at [k*OUT_W-1 -: OUT_W]
//   songout, note_code, gate                     - current pitch word, note code, note-valid gate
//   step_idx, step_tick, done                    - step position, advance pulse, one-shot finished
//
// Optional feature macro GATE_GAP_EN: drops gate/songout for the tail of each step
// (count >= tempo_div - tempo_div/8) so repeated notes re-articulate. Undefined: gate held all step.
module song_sequencer #(
   parameter int OUT_W     = 16,
   parameter int NOTE_W    = 6,
   parameter int NUM_NOTES = 36,
   parameter int ADDR_W    = 7,
   parameter int DIV_W     = 24
) (
   input  logic                       clk50,
   input  logic                       reset,
   input  logic                       play,
   input  logic                       loop_en,
   input  logic [DIV_W-1:0]           tempo_div,
   input  logic [ADDR_W:0]            song_len,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [NOTE_W-1:0]          wr_data,
   input  logic [NUM_NOTES*OUT_W-1:0] note_table,
   output logic [OUT_W-1:0]           songout,
   output logic [NOTE_W-1:0]          note_code,
   output logic                       gate,
   output logic [ADDR_W-1:0]          step_idx,
   output logic                       step_tick,
   output logic                       done
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [DIV_W-1:0]    count, count_nxt;
   logic [ADDR_W-1:0]   step, step_nxt;
   logic                tick_q, tick_nxt;
   logic                out_vld, out_vld_nxt;

   // Song RAM and its registered read port (no reset: contents survive reset).
   logic [NOTE_W-1:0]   ram [DEPTH];
   logic [NOTE_W-1:0]   rd_code;

   // Live compares against the current tempo and length.
   logic                boundary;
   logic                last_step;
   logic [ADDR_W:0]     len_m1;

   logic [OUT_W-1:0]    pitch;
   logic                code_ok;
   logic                in_gap;

   assign boundary  = (count >= tempo_div);
   assign len_m1    = song_len - (ADDR_W+1)'(1);
   // song_len lowered to 0 mid-song must still terminate the step, not wrap len_m1 to all-ones.
   assign last_step = (song_len == '0) || ({1'b0, step} >= len_m1);

   // ------------------------------------------------------------------
   // Song RAM: write port plus read-first synchronous read of the current step.
   // ------------------------------------------------------------------
   always_ff @(posedge clk50) begin
      if (wr_en) begin
         ram[wr_addr] <= wr_data;
      end
      rd_code <= ram[step];
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         count   <= '0;
         step    <= '0;
         tick_q  <= 1'b0;
         out_vld <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         step    <= step_nxt;
         tick_q  <= tick_nxt;
         out_vld <= out_vld_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state / datapath logic
   // PAUSE with play high behaves exactly like a PLAY cycle, so a step
   // always spends tempo_div+1 play-high cycles regardless of pauses.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      step_nxt  = step;
      tick_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (play) begin
               if (song_len != '0) begin
                  state_nxt = PLAY;
                  count_nxt = '0;
                  step_nxt  = '0;
               end else begin
                  state_nxt = DONE;
               end
            end
         end

         PLAY, PAUSE: begin
            if (!play) begin
               state_nxt = PAUSE;
            end else begin
               state_nxt = PLAY;
               if (boundary) begin
                  count_nxt = '0;
                  tick_nxt  = 1'b1;
                  if (last_step) begin
                     if (loop_en) begin
                        step_nxt = '0;
                     end else begin
                        state_nxt = DONE;
                     end
                  end else begin
                     step_nxt = step + ADDR_W'(1);
                  end
               end else begin
                  count_nxt = count + DIV_W'(1);
               end
            end
         end

         DONE: begin
            if (!play) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // rd_code is stale for the first cycle after leaving IDLE (step was just
      // forced to 0), so hold the outputs off for that cycle.
      out_vld_nxt = (state_nxt == PLAY) && (state != IDLE);
   end

   // ------------------------------------------------------------------
   // Pitch lookup: code 0 and codes above NUM_NOTES are silent.
   // ------------------------------------------------------------------
   always_comb begin
      pitch   = '0;
      code_ok = 1'b0;
      for (int k = 1; k <= NUM_NOTES; k++) begin
         if (rd_code == NOTE_W'(k)) begin
            pitch   = note_table[k*OUT_W-1 -: OUT_W];
            code_ok = 1'b1;
         end
      end
   end

`ifdef GATE_GAP_EN
   // Gap covers the last eighth of the step; for tempo_div < 8 this is just count == tempo_div.
   logic [DIV_W-1:0] gap_start;
   assign gap_start = tempo_div - (tempo_div >> 3);
   assign in_gap    = (count >= gap_start);
`else
   assign in_gap    = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs: decoded from registers, so an async reset clears them at once.
   // ------------------------------------------------------------------
   assign note_code = out_vld ? rd_code : '0;
   assign gate      = out_vld & code_ok & ~in_gap;
   assign songout   = gate ? pitch : '0;
   assign step_idx  = step;
   assign step_tick = tick_q;
   assign done      = (state == DONE);

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

   localparam int OUT_W     = 16;
   localparam int NOTE_W    = 6;
   localparam int NUM_NOTES = 36;
   localparam int ADDR_W    = 7;
   localparam int DIV_W     = 24;
   localparam int OBS_W     = OUT_W + NOTE_W + 1 + ADDR_W + 2;

   logic                       clk50 = 1'b0;
   logic                       reset = 1'b0;
   logic                       play = 1'b0;
   logic                       loop_en = 1'b0;
   logic [DIV_W-1:0]           tempo_div = '0;
   logic [ADDR_W:0]            song_len = '0;
   logic                       wr_en = 1'b0;
   logic [ADDR_W-1:0]          wr_addr = '0;
   logic [NOTE_W-1:0]          wr_data = '0;
   logic [NUM_NOTES*OUT_W-1:0] note_table = '0;
   logic [OUT_W-1:0]           songout;
   logic [NOTE_W-1:0]          note_code;
   logic                       gate;
   logic [ADDR_W-1:0]          step_idx;
   logic                       step_tick;
   logic                       done;

   song_sequencer dut (
      .clk50      (clk50),
      .reset      (reset),
      .play       (play),
      .loop_en    (loop_en),
      .tempo_div  (tempo_div),
      .song_len   (song_len),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .note_table (note_table),
      .songout    (songout),
      .note_code  (note_code),
      .gate       (gate),
      .step_idx   (step_idx),
      .step_tick  (step_tick),
      .done       (done)
   );

   always #5 clk50 = ~clk50;

   wire [OBS_W-1:0] obs_w = {songout, note_code, gate, step_idx, step_tick, done};

   int checks   = 0;
   int failures = 0;

   // Reference model state: song contents, configuration, and progress p =
   // number of play-high cycles spent inside the song since it started.
   logic [NOTE_W-1:0] ram_m [2**ADDR_W];
   logic [NOTE_W-1:0] song_q [$];
   int                p;
   int                m_div;
   int                m_len;
   bit                m_loop;
   bit                pl;
   bit                adv;
   logic [OBS_W-1:0]  expv;

   // Song over when p has covered every step (one-shot only).
   function automatic bit m_done(input int pp);
      return !m_loop && ((pp / (m_div + 1)) >= m_len);
   endfunction

   // Expected outputs after an edge: step = p / (div+1) (mod len when looping);
   // sounding note is the step occupied one cycle earlier; silent when the last
   // edge had play low, before the first note, or when finished.
   function automatic logic [OBS_W-1:0] model(input int pp, input bit pl_e, input bit adv_e);
      int per, idx, st, ridx, kc;
      bit dn, vld, gt, tk;
      logic [NOTE_W-1:0] cd;
      logic [OUT_W-1:0]  so;
      per  = m_div + 1;
      idx  = pp / per;
      dn   = !m_loop && (idx >= m_len);
      st   = dn ? (m_len - 1) : (idx % m_len);
      vld  = pl_e && (pp >= 1) && !dn;
      ridx = (pp >= 1) ? (((pp - 1) / per) % m_len) : 0;
      cd   = vld ? ram_m[ridx] : '0;
      kc   = int'(cd);
      gt   = vld && (kc >= 1) && (kc <= NUM_NOTES);
`ifdef GATE_GAP_EN
      if ((pp % per) >= (m_div - (m_div >> 3))) gt = 1'b0;
`endif
      so   = gt ? note_table[(kc-1)*OUT_W +: OUT_W] : '0;
      tk   = adv_e && ((pp % per) == 0);
      return {so, cd, gt, ADDR_W'(st), tk, dn};
   endfunction

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   task automatic go_idle();
      play  = 1'b0;
      wr_en = 1'b0;
      reset = 1'b0;
      #3;
      reset = 1'b1;
      tick();
   endtask

   task automatic set_cfg();
      tempo_div = DIV_W'(m_div);
      song_len  = (ADDR_W+1)'(m_len);
      loop_en   = m_loop;
   endtask

   task automatic load_song();
      for (int i = 0; i < song_q.size(); i++) begin
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(i);
         wr_data = song_q[i];
         ram_m[i] = song_q[i];
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic start_song();
      play = 1'b1;
      tick();
      p = 0;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b0;
      play  = 1'b1;
      tick();
      tick();
      checks++;
      if (obs_w !== '0) begin
         failures++;
         $display("FAIL reset_hold got=%h exp=%h", obs_w, {OBS_W{1'b0}});
      end
      play  = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (obs_w !== '0) begin
         failures++;
         $display("FAIL reset_idle got=%h exp=%h", obs_w, {OBS_W{1'b0}});
      end
   endtask

   task automatic test_one_shot();
      go_idle();
      song_q = '{6'd1, 6'd0, 6'd3, 6'd3};
      m_div = 9; m_len = 4; m_loop = 1'b0;
      set_cfg();
      load_song();
      start_song();
      checks++;
      if (obs_w !== model(0, 1'b1, 1'b0)) begin
         failures++;
         $display("FAIL one_shot_start got=%h exp=%h", obs_w, model(0, 1'b1, 1'b0));
      end
      for (int c = 1; c <= 50; c++) begin
         tick();
         adv = !m_done(p);
         if (adv) p++;
         expv = model(p, 1'b1, adv);
         checks++;
         if (obs_w !== expv) begin
            failures++;
            $display("FAIL one_shot cyc=%0d got=%h exp=%h", c, obs_w, expv);
         end
         if (c == 1) begin
            checks++;
            if (note_code !== 6'd1 || gate !== 1'b1) begin
               failures++;
               $display("FAIL first_note_latency note=%0d gate=%b exp note=1 gate=1", note_code, gate);
            end
         end
      end
      checks++;
      if (done !== 1'b1 || songout !== '0 || step_idx !== 7'd3) begin
         failures++;
         $display("FAIL one_shot_done done=%b songout=%h step=%0d exp 1/0/3", done, songout, step_idx);
      end
   endtask

   task automatic test_loop();
      int ticks, dones;
      go_idle();
      m_div = 9; m_len = 4; m_loop = 1'b1;
      set_cfg();
      start_song();
      ticks = 0;
      dones = 0;
      for (int c = 1; c <= 100; c++) begin
         tick();
         adv = !m_done(p);
         if (adv) p++;
         expv = model(p, 1'b1, adv);
         ticks += int'(step_tick);
         dones += int'(done);
         checks++;
         if (obs_w !== expv) begin
            failures++;
            $display("FAIL loop cyc=%0d got=%h exp=%h", c, obs_w, expv);
         end
      end
      checks++;
      if (ticks != 100 / (9 + 1) || dones != 0) begin
         failures++;
         $display("FAIL loop_ticks ticks=%0d dones=%0d exp ticks=10 dones=0", ticks, dones);
      end
   endtask

   task automatic test_pause();
      int  edges;
      bit  seen;
      go_idle();
      m_div = 9; m_len = 4; m_loop = 1'b0;
      set_cfg();
      start_song();
      for (int c = 0; c < 24; c++) begin
         tick();
         adv = !m_done(p);
         if (adv) p++;
      end
      checks++;
      if (step_idx !== 7'd2) begin
         failures++;
         $display("FAIL pause_position step=%0d exp=2", step_idx);
      end
      play = 1'b0;
      for (int c = 0; c < 25; c++) begin
         tick();
         expv = model(p, 1'b0, 1'b0);
         checks++;
         if (obs_w !== expv) begin
            failures++;
            $display("FAIL pause_hold cyc=%0d got=%h exp=%h", c, obs_w, expv);
         end
      end
      play  = 1'b1;
      edges = 0;
      seen  = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         edges++;
         adv = !m_done(p);
         if (adv) p++;
         expv = model(p, 1'b1, adv);
         checks++;
         if (obs_w !== expv) begin
            failures++;
            $display("FAIL pause_resume cyc=%0d got=%h exp=%h", c, obs_w, expv);
         end
         if (step_idx === 7'd3) seen = 1'b1;
      end
      checks++;
      if (!seen || edges != (9 + 1) - 4) begin
         failures++;
         $display("FAIL pause_resume_len seen=%b edges=%0d exp seen=1 edges=6", seen, edges);
      end
   endtask

   task automatic test_bad_code_and_empty();
      go_idle();
      song_q = '{6'd40};
      m_div = 3; m_len = 1; m_loop = 1'b1;
      set_cfg();
      load_song();
      start_song();
      tick();
      adv = !m_done(p);
      if (adv) p++;
      checks++;
      if (note_code !== 6'd40 || gate !== 1'b0 || songout !== '0) begin
         failures++;
         $display("FAIL bad_code note=%0d gate=%b songout=%h exp 40/0/0", note_code, gate, songout);
      end
      go_idle();
      m_len = 0;
      set_cfg();
      play = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (done !== 1'b1 || step_tick !== 1'b0 || gate !== 1'b0) begin
            failures++;
            $display("FAIL empty_song cyc=%0d done=%b tick=%b gate=%b exp 1/0/0", c, done, step_tick, gate);
         end
      end
   endtask

   task automatic test_reset_mid();
      go_idle();
      song_q.delete();
      for (int i = 0; i < 4; i++) song_q.push_back(NOTE_W'($urandom_range(1, NUM_NOTES)));
      m_div = 9; m_len = 4; m_loop = 1'b1;
      set_cfg();
      load_song();
      start_song();
      for (int c = 0; c < 14; c++) tick();
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (obs_w !== '0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", obs_w, {OBS_W{1'b0}});
      end
      #2;
      reset = 1'b1;
      tick();
      p = 0;
      for (int c = 0; c <= 30; c++) begin
         if (c > 0) begin
            tick();
            adv = !m_done(p);
            if (adv) p++;
         end else begin
            adv = 1'b0;
         end
         expv = model(p, 1'b1, adv);
         checks++;
         if (obs_w !== expv) begin
            failures++;
            $display("FAIL reset_restart cyc=%0d got=%h exp=%h", c, obs_w, expv);
         end
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 6; s++) begin
         go_idle();
         m_len  = $urandom_range(1, 12);
         m_div  = $urandom_range(0, 6);
         m_loop = 1'($urandom_range(0, 1));
         song_q.delete();
         for (int i = 0; i < m_len; i++) song_q.push_back(NOTE_W'($urandom_range(0, 63)));
         set_cfg();
         load_song();
         start_song();
         for (int c = 1; c <= 150; c++) begin
            pl   = m_done(p) ? 1'b1 : ($urandom_range(0, 99) < 80);
            play = pl;
            tick();
            adv = pl && !m_done(p);
            if (adv) p++;
            expv = model(p, pl, adv);
            checks++;
            if (obs_w !== expv) begin
               failures++;
               $display("FAIL random song=%0d cyc=%0d got=%h exp=%h", s, c, obs_w, expv);
            end
         end
      end
   endtask

`ifdef GATE_GAP_EN
   task automatic test_gate_gap();
      int hi;
      go_idle();
      song_q = '{6'd5, 6'd5};
      m_div = 15; m_len = 2; m_loop = 1'b1;
      set_cfg();
      load_song();
      start_song();
      hi = 0;
      for (int c = 1; c <= 48; c++) begin
         tick();
         adv = !m_done(p);
         if (adv) p++;
         expv = model(p, 1'b1, adv);
         if (c >= 17) hi += int'(gate);
         checks++;
         if (obs_w !== expv) begin
            failures++;
            $display("FAIL gate_gap cyc=%0d got=%h exp=%h", c, obs_w, expv);
         end
      end
      checks++;
      if (hi != 2 * 14) begin
         failures++;
         $display("FAIL gate_gap_len high=%0d exp=28", hi);
      end
   endtask
`endif

   initial begin
      for (int k = 0; k < NUM_NOTES; k++) note_table[k*OUT_W +: OUT_W] = OUT_W'($urandom_range(1, 65535));
      test_reset();
      test_one_shot();
      test_loop();
      test_pause();
      test_bad_code_and_empty();
      test_reset_mid();
      test_random();
`ifdef GATE_GAP_EN
      test_gate_gap();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
